n_bit_pipelined_adder: RTL and testbench
========================================

// Module: n_bit_pipelined_adder
// PURPOSE
//   Pipelined unsigned adder: sum = in1 + in2 + cin, one CHUNK_WIDTH slice per stage, carry registered between stages.
//   Complementary add path to the combinational CSA subtractor in the FIR datapath.
//   Used where the tap-sum width would break timing in a single cycle.
//   Valid/ready handshake on both sides; whole-pipe stall under output backpressure.
// PARAMETERS
//   IN_DATAWIDTH   4   operand width (unsigned)
//   OUT_DATAWIDTH  IN_DATAWIDTH+1   result width; must equal IN_DATAWIDTH+1
//   CHUNK_WIDTH    2   bits added per stage; 1..IN_DATAWIDTH
//   STAGES (localparam) = ceil(IN_DATAWIDTH/CHUNK_WIDTH); last chunk may be narrower
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous, active-high reset
//   in_valid   in   1              operands valid
//   in_ready   out  1              block accepts operands this cycle
//   in1        in   IN_DATAWIDTH   operand A
//   in2        in   IN_DATAWIDTH   operand B
//   cin        in   1              carry in
//   sub        in   1              only with N_BIT_ADDER_SUB_EN: 1 = subtract
//   out_valid  out  1              sum valid
//   out_ready  in   1              downstream accepts sum
//   sum        out  OUT_DATAWIDTH  result
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): all stage valid bits, carries, partial sums and sum cleared to 0.
//     out_valid=0. in_ready=1 in the first cycle after reset. Reset mid-operation discards in-flight data silently.
//   - Transfer in: in_valid & in_ready at the edge. Transfer out: out_valid & out_ready at the edge.
//   - Stall rule: advance = !out_valid | out_ready; in_ready = advance (combinational).
//     When advance=0, every stage register holds; no stage bubble-collapse.
//   - Stage k (0..STAGES-1), on advance:
//     * adds chunk k of A and B plus carry from stage k-1 (stage 0 uses cin);
//     * registers the sum chunk and the carry;
//     * forwards the lower result chunks computed so far and the not-yet-added upper operand chunks.
//   - Last stage: sum[OUT_DATAWIDTH-1] = final carry out.
//   - Latency: STAGES cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle.
//   - Bubbles (advance with in_valid=0) propagate as valid=0. Data regs may update freely; sum is don't-care while out_valid=0.
//   - sum and out_valid are registered outputs; sum is stable while out_valid=1 & out_ready=0.
//   - Wrap-around: none; OUT_DATAWIDTH holds the max (2^N-1)*2+1 exactly.
// CONFIGURATION
//   N_BIT_ADDER_SUB_EN defined:
//     - `sub` port present and captured with operands.
//     - sub=1: operands zero-extended to OUT_DATAWIDTH; B inverted across all OUT_DATAWIDTH bits; carry in = ~cin.
//     - sum = (in1 - in2 - cin) mod 2^OUT_DATAWIDTH, bit-exact with the CSA subtractor. Same latency.
//     - sub=0: identical to add mode.
//   N_BIT_ADDER_SUB_EN undefined:
//     - no `sub` port; add only.
//     - Top stage uses no extension logic.
// TESTING  (IN_DATAWIDTH=4, CHUNK_WIDTH=2 -> latency 2)
//   1. Reset with in_valid=1 held -> out_valid=0, sum=0 during reset; first input after reset appears exactly 2 cycles later.
//   2. Exhaustive in1,in2 0..15, cin 0/1, back-to-back, out_ready=1 -> sum==in1+in2+cin each cycle.
//      Example: 15+15+1 -> 31 (5'b11111). Stream stays gapless.
//   3. in1=9, in2=7, cin=0 with out_ready=0 for 5 cycles -> out_valid=1, sum=16 held; in_ready=0.
//      Release -> 16 consumed once; following inputs in order, none lost or duplicated.
//   4. Random in_valid/out_ready (50%) for 1000 transactions vs scoreboard -> zero mismatches; order preserved.
//   5. Assert rst while 2 results in flight -> outputs cleared next cycle; no stale result appears afterwards.
//   6. With N_BIT_ADDER_SUB_EN: sub=1, in1=3, in2=5, cin=1 -> sum=5'b11101 (-3 mod 32).
//      Exhaustive sub sweep matches i-j-cin mod 32.

Source files
------------

// File: rtl/n_bit_pipelined_adder.sv
// Pipelined unsigned adder: one CHUNK_WIDTH slice per stage, carry registered between stages,
// valid/ready on both sides with a whole-pipe stall. Optional subtract mode: N_BIT_ADDER_SUB_EN.
module n_bit_pipelined_adder #(
  parameter int IN_DATAWIDTH  = 4,
  parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int CHUNK_WIDTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_DATAWIDTH-1:0]  in1,
  input  logic [IN_DATAWIDTH-1:0]  in2,
  input  logic                     cin,
`ifdef N_BIT_ADDER_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_DATAWIDTH-1:0] sum
);

  localparam int STAGES = (IN_DATAWIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;

  function automatic int chunk_lo(input int k);
    return k * CHUNK_WIDTH;
  endfunction

  function automatic int chunk_w(input int k);
    return (IN_DATAWIDTH - chunk_lo(k) < CHUNK_WIDTH) ? IN_DATAWIDTH - chunk_lo(k) : CHUNK_WIDTH;
  endfunction

  logic [IN_DATAWIDTH-1:0]  a_q [STAGES], a_d [STAGES], in_a [STAGES];
  logic [IN_DATAWIDTH-1:0]  b_q [STAGES], b_d [STAGES], in_b [STAGES];
  logic [OUT_DATAWIDTH-1:0] s_q [STAGES], s_d [STAGES], in_s [STAGES];
  logic                     c_q [STAGES], c_d [STAGES], in_c [STAGES];
  logic                     v_q [STAGES], v_d [STAGES], in_v [STAGES];
`ifdef N_BIT_ADDER_SUB_EN
  logic                     sub_q [STAGES], sub_d [STAGES], in_sub [STAGES];
`endif

  logic                   advance;
  logic [CHUNK_WIDTH-1:0] ca, cb;
  logic [CHUNK_WIDTH:0]   t, t_sh;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];

  // Stage 0 is fed from the ports; every later stage from its predecessor's registers.
  always_comb begin
    in_a[0] = in1;
    in_s[0] = '0;
    in_v[0] = in_valid;
`ifdef N_BIT_ADDER_SUB_EN
    in_b[0]   = sub ? ~in2 : in2;
    in_c[0]   = cin ^ sub;
    in_sub[0] = sub;
`else
    in_b[0] = in2;
    in_c[0] = cin;
`endif
    for (int k = 1; k < STAGES; k++) begin
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = s_q[k-1];
      in_c[k] = c_q[k-1];
      in_v[k] = v_q[k-1];
`ifdef N_BIT_ADDER_SUB_EN
      in_sub[k] = sub_q[k-1];
`endif
    end
  end

  // NOTE: the per-chunk temporaries are fully assigned before use in every iteration, so no latch forms.
  always_comb begin
    ca   = '0;
    cb   = '0;
    t    = '0;
    t_sh = '0;
    for (int k = 0; k < STAGES; k++) begin
      ca     = CHUNK_WIDTH'(in_a[k] >> chunk_lo(k));
      cb     = CHUNK_WIDTH'(in_b[k] >> chunk_lo(k));
      t      = {1'b0, ca} + {1'b0, cb} + {{CHUNK_WIDTH{1'b0}}, in_c[k]};
      t_sh   = t >> chunk_w(k);
      c_d[k] = t_sh[0];
      // The last chunk also deposits its carry-out into the top result bit.
      if (k == STAGES - 1) begin
        s_d[k] = in_s[k] | (OUT_DATAWIDTH'(t) << chunk_lo(k));
`ifdef N_BIT_ADDER_SUB_EN
        s_d[k][OUT_DATAWIDTH-1] = s_d[k][OUT_DATAWIDTH-1] ^ in_sub[k];
`endif
      end else begin
        s_d[k] = in_s[k] | (OUT_DATAWIDTH'(t[CHUNK_WIDTH-1:0]) << chunk_lo(k));
      end
      a_d[k] = in_a[k];
      b_d[k] = in_b[k];
      v_d[k] = in_v[k];
`ifdef N_BIT_ADDER_SUB_EN
      sub_d[k] = in_sub[k];
`endif
    end
  end

  // NOTE: data registers are reset along with valids so sum reads 0 during and right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
`ifdef N_BIT_ADDER_SUB_EN
        sub_q[k] <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
`ifdef N_BIT_ADDER_SUB_EN
        sub_q[k] <= sub_d[k];
`endif
      end
    end
  end

  // Final-stage operand/carry copies have no consumer.
  logic unused_last;
`ifdef N_BIT_ADDER_SUB_EN
  assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1], sub_q[STAGES-1]};
`else
  assign unused_last = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1]};
`endif

endmodule

// File: tb/tb_n_bit_pipelined_adder.sv
// Directed testbench for n_bit_pipelined_adder (IN_DATAWIDTH=4, CHUNK_WIDTH=2, latency 2).
module tb_n_bit_pipelined_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in1, in2;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] sum;
`ifdef N_BIT_ADDER_SUB_EN
  logic       sub;
`endif

  int tests = 0;
  int fails = 0;
  int q[$];

  n_bit_pipelined_adder #(.IN_DATAWIDTH(4), .OUT_DATAWIDTH(5), .CHUNK_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin),
`ifdef N_BIT_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int c);
    in1 = 4'(a);
    in2 = 4'(b);
    cin = 1'(c);
  endtask

  initial begin
    int sent, recv, cyc, e;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    drive(5, 6, 1);
`ifdef N_BIT_ADDER_SUB_EN
    sub = 1'b0;
`endif

    // Reset with in_valid held high
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    tick();
    check("lat_cycle1_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
    tick();
    check("lat_cycle2_valid", 32'(out_valid), 1);
    check("lat_cycle2_sum", 32'(sum), 12);
    tick();
    check("bubble_valid", 32'(out_valid), 0);

    // Exhaustive back-to-back sweep
    for (int i = 0; i <= 512; i++) begin
      if (i < 512) begin
        in_valid = 1'b1;
        drive((i >> 5) & 15, (i >> 1) & 15, i & 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        e = (((i - 1) >> 5) & 15) + (((i - 1) >> 1) & 15) + ((i - 1) & 1);
        check("sweep_valid", 32'(out_valid), 1);
        check("sweep_sum", 32'(sum), 32'(e));
      end
    end
    tick();
    check("sweep_drained", 32'(out_valid), 0);

    // Backpressure: 9+7 held for 5 cycles, then 1+1 and 2+2 follow in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(9, 7, 0);
    tick();
    drive(1, 1, 0);
    tick();
    drive(2, 2, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 1);
      check("stall_sum", 32'(sum), 16);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("release_next_valid", 32'(out_valid), 1);
    check("release_next_sum", 32'(sum), 2);
    tick();
    check("release_third_valid", 32'(out_valid), 1);
    check("release_third_sum", 32'(sum), 4);
    tick();
    check("release_empty", 32'(out_valid), 0);

    // Random valid/ready against a queue model
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_unexpected_output", 32'(q.size()), 1);
        end else begin
          check("rand_sum", 32'(sum), 32'(q.pop_front()));
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(int'(in1) + int'(in2) + int'(cin));
        sent++;
      end
      tick();
      cyc++;
    end
    check("rand_received", 32'(recv), 1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset with two results in flight
    in_valid = 1'b1;
    drive(3, 4, 0);
    tick();
    drive(8, 8, 1);
    tick();
    check("flight_valid", 32'(out_valid), 1);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_sum", 32'(sum), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", 32'(out_valid), 0);
    end

`ifdef N_BIT_ADDER_SUB_EN
    // Subtract mode
    in_valid = 1'b1;
    sub = 1'b1;
    drive(3, 5, 1);
    tick();
    in_valid = 1'b0;
    tick();
    check("sub_valid", 32'(out_valid), 1);
    check("sub_3_5_1", 32'(sum), 29);
    for (int i = 0; i <= 512; i++) begin
      if (i < 512) begin
        in_valid = 1'b1;
        drive((i >> 5) & 15, (i >> 1) & 15, i & 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        e = ((((i - 1) >> 5) & 15) - (((i - 1) >> 1) & 15) - ((i - 1) & 1)) & 31;
        check("subsweep_valid", 32'(out_valid), 1);
        check("subsweep_sum", 32'(sum), 32'(e));
      end
    end
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
